line_write_buffer: RTL
======================

# line_write_buffer

Line-granular write-back buffer between the cache arbiter and the cacheline adaptor. It absorbs dirty-line evictions (256-bit writes) so that line fills (reads) reach memory first. It forwards buffered data to reads that hit a pending entry. It drains entries to memory whenever the downstream path is otherwise idle or the buffer is full.

## Interface
- DEPTH, 2: number of buffered lines; legal range 1–4.
- clk  in  1  clock; every register updates on its rising edge.
- rst  in  1  reset, asynchronous and active-high.
- mem_read  in  1  arbiter line read; held high until mem_resp.
- mem_write  in  1  arbiter line write; held high until mem_resp; never asserted together with mem_read.
- mem_address  in  32  line address; bits [4:0] ignored.
- mem_wdata  in  256  write line.
- mem_rdata  out  256  read line; valid while mem_resp is high.
- mem_resp  out  1  one-cycle completion pulse to the arbiter.
- pmem_read  out  1  line read to the adaptor; held high until pmem_resp.
- pmem_write  out  1  line write to the adaptor; held high until pmem_resp.
- pmem_address  out  32  line address, with bits [4:0] = 0.
- pmem_wdata  out  256  write line.
- pmem_rdata  in  256  read line; valid while pmem_resp is high.
- pmem_resp  in  1  adaptor completion pulse.

## Operation
- Storage is a FIFO of DEPTH entries. Each entry holds tag = address[31:5] (27 bits), 256-bit data and a valid bit. The count is $clog2(DEPTH+1) bits wide.
- A hit is a valid entry whose tag equals mem_address[31:5]. At most one entry matches, because writes coalesce.
- FSM states are IDLE, READ_MEM, DRAIN and RESP. IDLE decides the next state by the first rule below that applies:
  - Write that hits: overwrite that entry's data in place; FIFO position is unchanged. Go to RESP.
  - Write that misses with count < DEPTH: push at the tail. Go to RESP.
  - Write that misses with count == DEPTH: go to DRAIN. The write is retried after the drain.
  - Read that hits: latch the entry's data into the response register. Go to RESP; no memory access is made.
  - Read that misses: go to READ_MEM. Reads take priority over draining.
  - No request and count > 0: go to DRAIN.
  - Otherwise stay in IDLE.
- READ_MEM:
  - Drive pmem_read = 1 and pmem_address = {mem_address[31:5], 5'b0}.
  - On pmem_resp, latch pmem_rdata and go to RESP.
- DRAIN:
  - Drive pmem_write = 1 with the head entry's address and data.
  - On pmem_resp, pop the head and go to IDLE.
  - A drain cannot be interrupted, so a read to the draining line waits and then misses to updated memory.
- RESP:
  - Drive mem_resp = 1 and mem_rdata from the response register. mem_rdata holds stale data after a write.
  - Go to IDLE. The arbiter drops or changes its request in the following cycle.
- The pmem_* outputs are 0 in IDLE and RESP, and pmem_wdata is 0 outside DRAIN.

## Timing
- Reset values:
  - state = IDLE, count = 0, all valid bits = 0, response register = 0.
  - All outputs are 0: mem_resp, mem_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata.
- Reset asserted mid-transaction aborts the transaction immediately and discards all buffered lines. The adaptor shares rst.
- Latencies, with the request first seen in IDLE at cycle T:
  - Write accepted: mem_resp at T+1.
  - Read hit: mem_resp at T+1.
  - Read miss: pmem_read from T+1 up to and including the pmem_resp cycle P; mem_resp at P+1.
  - Write to a full buffer: DRAIN from T+1; pmem_resp at cycle D; IDLE at D+1; push at D+1; mem_resp at D+2.
- pmem_read and pmem_write are never high in the same cycle.
- pmem_address and pmem_wdata stay stable while pmem_read or pmem_write is high.
- pmem_resp is ignored in IDLE and RESP.
- With DEPTH = 1, full and empty alternate, and every write that misses while the buffer is occupied drains first.

## Structure
- Package lwb_pkg holds:
  - lwb_line_t: logic [255:0].
  - lwb_tag_t: logic [26:0].
  - The entry struct: valid, tag, data.
  - The state enum.
  - The default DEPTH constant.
- Sub-module lwb_queue holds the storage: entry array, head/tail pointers (mod DEPTH) and count. It provides:
  - Push, pop and coalesce-write.
  - A combinational hit-match output with the hit index and hit data.
  - Head entry outputs.
- line_write_buffer holds the FSM and the response register.

## Test plan
- Eviction then fill to different lines:
  - Stimulus: write 0x0000_1000 with data A, then read 0x0000_2000.
  - Response: write mem_resp at T+1 with no pmem_write. pmem_read goes out for 0x0000_2000 before any drain. After that, an idle interval drains A to 0x0000_1000.
- Forwarding:
  - Stimulus: write 0x0000_1020 with data B, then read 0x0000_1034.
  - Response: mem_resp at T+1 with mem_rdata = B, and no pmem_read.
- Coalescing:
  - Stimulus: write 0x40 = C1, then write 0x40 = C2, then idle.
  - Response: exactly one pmem_write, to address 0x40, with data C2.
- Full buffer, DEPTH = 2:
  - Stimulus: writes to 0x100, 0x200 and 0x300 back to back, with the adaptor answering after 5 cycles.
  - Response: the third write drains 0x100 first and receives mem_resp 2 cycles after that pmem_resp. Final drain order is 0x200 then 0x300.
- Read during drain:
  - Stimulus: a drain of 0x500 is in flight when a read of 0x500 arrives.
  - Response: pmem_write completes first, then pmem_read for 0x500 is issued.
- Reset:
  - Stimulus: assert rst during READ_MEM with 2 entries buffered.
  - Response: all outputs are 0 within the reset cycle, and no pmem_write occurs after reset is released.

Source files
------------

// File: rtl/lwb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lwb_pkg
//  Description : Shared types and constants for the line write buffer.
//                Holds the line/tag types, the buffered-entry record, the
//                controller state encoding and the default buffer depth.
//  Revision    : 1.0 - initial release
// ============================================================================
package lwb_pkg;

    localparam int c_DEFAULT_DEPTH = 2;
    localparam int c_LINE_W        = 256;
    localparam int c_TAG_W         = 27;
    localparam int c_OFFSET_W      = 5;

    typedef logic [c_LINE_W-1:0] lwb_line_t;
    typedef logic [c_TAG_W-1:0]  lwb_tag_t;

    typedef struct packed {
        logic      valid;
        lwb_tag_t  tag;
        lwb_line_t data;
    } lwb_entry_t;

    // Controller state encoding
    typedef logic [1:0] lwb_state_t;
    localparam lwb_state_t c_ST_IDLE     = 2'd0;
    localparam lwb_state_t c_ST_READ_MEM = 2'd1;
    localparam lwb_state_t c_ST_DRAIN    = 2'd2;
    localparam lwb_state_t c_ST_RESP     = 2'd3;

    // Rebuild a line-aligned byte address from a stored tag.
    function automatic logic [31:0] lwb_line_addr(input lwb_tag_t tag);
        return {tag, {c_OFFSET_W{1'b0}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/lwb_queue.sv
`default_nettype none
// ============================================================================
//  Module      : lwb_queue
//  Description : FIFO storage for buffered dirty lines. Entries are pushed at
//                the tail, popped from the head, and may be overwritten in
//                place (coalescing) without changing their FIFO position.
//                A combinational tag lookup reports a hit, its index and data.
//  Ports       : clk, rst          - clock, asynchronous active-high reset
//                i_push*           - append a new line at the tail
//                i_pop             - retire the head entry
//                i_coal_*          - overwrite the data of an existing entry
//                i_lookup_tag      - tag to match against valid entries
//                o_hit*            - match result, index and data
//                o_head_tag/data   - oldest entry (next to drain)
//                o_count, o_full   - occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module lwb_queue
    import lwb_pkg::*;
#(
    parameter int DEPTH = c_DEFAULT_DEPTH,
    parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  lwb_tag_t         i_push_tag,
    input  lwb_line_t        i_push_data,
    input  logic             i_pop,
    input  logic             i_coal_we,
    input  logic [IDX_W-1:0] i_coal_idx,
    input  lwb_line_t        i_coal_data,
    input  lwb_tag_t         i_lookup_tag,
    output logic             o_hit,
    output logic [IDX_W-1:0] o_hit_idx,
    output lwb_line_t        o_hit_data,
    output lwb_tag_t         o_head_tag,
    output lwb_line_t        o_head_data,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full
);

    lwb_entry_t       r_entries [DEPTH];
    logic [IDX_W-1:0] r_head;
    logic [IDX_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic             w_do_push;
    logic             w_do_pop;
    logic             w_hit;
    logic [IDX_W-1:0] w_hit_idx;
    lwb_line_t        w_hit_data;

    function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
        if (p == IDX_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + IDX_W'(1);
    endfunction

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_count   = r_count;

    // Guard against overflow/underflow so a misbehaving controller cannot
    // corrupt the pointers.
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && (r_count != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_coal_we) begin
                r_entries[i_coal_idx].data <= i_coal_data;
            end
            if (w_do_pop) begin
                r_entries[r_head].valid <= 1'b0;
                r_head                  <= ptr_inc(r_head);
            end
            if (w_do_push) begin
                r_entries[r_tail] <= '{valid: 1'b1, tag: i_push_tag, data: i_push_data};
                r_tail            <= ptr_inc(r_tail);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Writes coalesce, so at most one valid entry can carry a given tag;
    // the first match is taken.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_hit_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!w_hit && r_entries[i].valid && (r_entries[i].tag == i_lookup_tag)) begin
                w_hit      = 1'b1;
                w_hit_idx  = IDX_W'(i);
                w_hit_data = r_entries[i].data;
            end
        end
    end

    assign o_hit       = w_hit;
    assign o_hit_idx   = w_hit_idx;
    assign o_hit_data  = w_hit_data;
    assign o_head_tag  = r_entries[r_head].tag;
    assign o_head_data = r_entries[r_head].data;

endmodule
`default_nettype wire

// File: rtl/line_write_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : line_write_buffer
//  Description : Line-granular write-back buffer between the cache arbiter
//                and the cacheline adaptor. Dirty-line writes are absorbed
//                into a small FIFO so line fills reach memory first; reads
//                that hit a buffered line are answered from the buffer; the
//                buffer drains when the downstream path is idle or full.
//  Ports       : clk, rst                     - clock, async active-high reset
//                mem_read/write/address/wdata - arbiter request
//                mem_rdata, mem_resp          - arbiter response
//                pmem_read/write/address/wdata- adaptor request
//                pmem_rdata, pmem_resp        - adaptor response
//  Revision    : 1.0 - initial release
// ============================================================================
module line_write_buffer
    import lwb_pkg::*;
#(
    parameter int DEPTH = c_DEFAULT_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [31:0]  mem_address,
    input  logic [255:0] mem_wdata,
    output logic [255:0] mem_rdata,
    output logic         mem_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
);

    localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    lwb_state_t         r_state;
    lwb_state_t         w_next_state;
    lwb_line_t          r_resp_data;

    lwb_tag_t           w_req_tag;
    logic               w_hit;
    logic [c_IDX_W-1:0] w_hit_idx;
    lwb_line_t          w_hit_data;
    lwb_tag_t           w_head_tag;
    lwb_line_t          w_head_data;
    logic [c_CNT_W-1:0] w_count;
    logic               w_full;

    logic               w_push;
    logic               w_pop;
    logic               w_coal_we;
    logic               w_load_hit;
    logic               w_load_pmem;

    // The byte offset inside a line plays no part in buffering.
    logic               w_unused_offset;
    assign w_unused_offset = ^mem_address[c_OFFSET_W-1:0];

    assign w_req_tag = mem_address[31:c_OFFSET_W];

    lwb_queue #(
        .DEPTH (DEPTH),
        .IDX_W (c_IDX_W),
        .CNT_W (c_CNT_W)
    ) u_queue (
        .clk          (clk),
        .rst          (rst),
        .i_push       (w_push),
        .i_push_tag   (w_req_tag),
        .i_push_data  (mem_wdata),
        .i_pop        (w_pop),
        .i_coal_we    (w_coal_we),
        .i_coal_idx   (w_hit_idx),
        .i_coal_data  (mem_wdata),
        .i_lookup_tag (w_req_tag),
        .o_hit        (w_hit),
        .o_hit_idx    (w_hit_idx),
        .o_hit_data   (w_hit_data),
        .o_head_tag   (w_head_tag),
        .o_head_data  (w_head_data),
        .o_count      (w_count),
        .o_full       (w_full)
    );

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ----------------------------------------------------------- next state
    // A write to a full buffer drains the head first and is then retried
    // from IDLE, where it finds room. Reads are preferred over draining.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (mem_write) begin
                    w_next_state = (w_hit || !w_full) ? c_ST_RESP : c_ST_DRAIN;
                end else if (mem_read) begin
                    w_next_state = w_hit ? c_ST_RESP : c_ST_READ_MEM;
                end else if (w_count != '0) begin
                    w_next_state = c_ST_DRAIN;
                end
            end
            c_ST_READ_MEM: begin
                if (pmem_resp) begin
                    w_next_state = c_ST_RESP;
                end
            end
            c_ST_DRAIN: begin
                if (pmem_resp) begin
                    w_next_state = c_ST_IDLE;
                end
            end
            c_ST_RESP: begin
                w_next_state = c_ST_IDLE;
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        w_push       = 1'b0;
        w_pop        = 1'b0;
        w_coal_we    = 1'b0;
        w_load_hit   = 1'b0;
        w_load_pmem  = 1'b0;
        mem_resp     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        case (r_state)
            c_ST_IDLE: begin
                if (mem_write) begin
                    w_coal_we = w_hit;
                    w_push    = !w_hit && !w_full;
                end else if (mem_read) begin
                    w_load_hit = w_hit;
                end
            end
            c_ST_READ_MEM: begin
                pmem_read    = 1'b1;
                pmem_address = {w_req_tag, {c_OFFSET_W{1'b0}}};
                w_load_pmem  = pmem_resp;
            end
            c_ST_DRAIN: begin
                // The queue is untouched while draining, so the head entry
                // (and thus address/data) stays stable until pmem_resp.
                pmem_write   = 1'b1;
                pmem_address = lwb_line_addr(w_head_tag);
                pmem_wdata   = w_head_data;
                w_pop        = pmem_resp;
            end
            c_ST_RESP: begin
                mem_resp = 1'b1;
            end
            default: begin
                mem_resp = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------ response register
    // Only reads update it; after a write the arbiter sees the stale value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resp_data <= '0;
        end else if (w_load_hit) begin
            r_resp_data <= w_hit_data;
        end else if (w_load_pmem) begin
            r_resp_data <= pmem_rdata;
        end
    end

    assign mem_rdata = r_resp_data;

endmodule
`default_nettype wire
